// File: rtl/instruction_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_controller
// Brief    : Sequential fetch PC generation, request issue with an outstanding
//            cap, throttling, and redirect flush/drain toward the inst buffer.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_controller #(
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iREDIRECT_VALID,
    input  logic [31:0] iREDIRECT_ADDR,
    input  logic        iFETCH_STOP,
    input  logic        iLOCK,
    output logic        oMEM_REQ,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_BUSY,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_DATA,
    input  logic        iMEM_PAGEFAULT,
    output logic        oINST_VALID,
    output logic [31:0] oINST,
    output logic [31:0] oPC,
    output logic        oPAGEFAULT,
    output logic        oFREE_REFRESH,
    output logic        oERROR
);

    localparam logic [0:0] c_FETCH   = 1'b0;
    localparam logic [0:0] c_DRAIN   = 1'b1;
    localparam logic [2:0] c_MAX_OUT = 3'(MAX_OUTSTANDING);

    logic [0:0]  r_state;
    logic [31:0] r_fetchPc;
    logic [31:0] r_respPc;
    logic [31:0] r_target;
    logic [2:0]  r_outstanding;
    logic        r_instValid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_pageFault;
    logic        r_freeRefresh;
    logic        r_error;

    logic        w_issue;
    logic        w_accept;
    logic        w_spurious;
    logic        w_respTaken;
    logic        w_forward;
    logic [2:0]  w_outNext;
    logic [31:0] w_redirTarget;

    // Request is held low while reset is asserted so the memory side never
    // sees a request during reset.
    assign w_issue = !iRESET && (r_state == c_FETCH) && !iREDIRECT_VALID
                     && !iFETCH_STOP && !iLOCK && (r_outstanding < c_MAX_OUT);
    assign w_accept      = w_issue && !iMEM_BUSY;
    assign w_spurious    = iMEM_VALID && (r_outstanding == 3'd0) && !w_accept;
    assign w_respTaken   = iMEM_VALID && !w_spurious;
    assign w_forward     = (r_state == c_FETCH) && !iREDIRECT_VALID && w_respTaken;
    assign w_redirTarget = {iREDIRECT_ADDR[31:2], 2'b00};

    always_comb begin
        w_outNext = r_outstanding;
        case ({w_accept, w_respTaken})
            2'b10:   w_outNext = r_outstanding + 3'd1;
            2'b01:   w_outNext = r_outstanding - 3'd1;
            default: w_outNext = r_outstanding;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state       <= c_FETCH;
            r_fetchPc     <= RESET_PC;
            r_respPc      <= RESET_PC;
            r_target      <= RESET_PC;
            r_outstanding <= 3'd0;
            r_instValid   <= 1'b0;
            r_inst        <= 32'h0;
            r_pc          <= RESET_PC;
            r_pageFault   <= 1'b0;
            r_freeRefresh <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_outstanding <= w_outNext;
            r_instValid   <= w_forward;
            r_freeRefresh <= iREDIRECT_VALID;

            // A response while locked means the cap exceeds buffer headroom.
            if (w_spurious || (w_forward && iLOCK)) begin
                r_error <= 1'b1;
            end

            if (w_forward) begin
                r_inst      <= iMEM_DATA;
                r_pageFault <= iMEM_PAGEFAULT;
                r_pc        <= r_respPc;
                r_respPc    <= r_respPc + 32'd4;
            end

            if (w_accept) begin
                r_fetchPc <= r_fetchPc + 32'd4;
            end

            if (iREDIRECT_VALID) begin
                r_target <= w_redirTarget;
                if (w_outNext == 3'd0) begin
                    r_fetchPc <= w_redirTarget;
                    r_respPc  <= w_redirTarget;
                    r_state   <= c_FETCH;
                end else begin
                    r_state   <= c_DRAIN;
                end
            end else if ((r_state == c_DRAIN) && (w_outNext == 3'd0)) begin
                r_fetchPc <= r_target;
                r_respPc  <= r_target;
                r_state   <= c_FETCH;
            end
        end
    end

    assign oMEM_REQ      = w_issue;
    assign oMEM_ADDR     = r_fetchPc;
    assign oINST_VALID   = r_instValid;
    assign oINST         = r_inst;
    assign oPC           = r_pc;
    assign oPAGEFAULT    = r_pageFault;
    assign oFREE_REFRESH = r_freeRefresh;
    assign oERROR        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_controller
// Brief    : Directed cycle-by-cycle bench for instruction_fetch_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_controller;

    logic        iCLOCK;
    logic        iRESET;
    logic        iREDIRECT_VALID;
    logic [31:0] iREDIRECT_ADDR;
    logic        iFETCH_STOP;
    logic        iLOCK;
    logic        oMEM_REQ;
    logic [31:0] oMEM_ADDR;
    logic        iMEM_BUSY;
    logic        iMEM_VALID;
    logic [31:0] iMEM_DATA;
    logic        iMEM_PAGEFAULT;
    logic        oINST_VALID;
    logic [31:0] oINST;
    logic [31:0] oPC;
    logic        oPAGEFAULT;
    logic        oFREE_REFRESH;
    logic        oERROR;

    int checks = 0;
    int errors = 0;

    instruction_fetch_controller #(
        .MAX_OUTSTANDING(4),
        .RESET_PC       (32'h0000_0000)
    ) dut (
        .iCLOCK         (iCLOCK),
        .iRESET         (iRESET),
        .iREDIRECT_VALID(iREDIRECT_VALID),
        .iREDIRECT_ADDR (iREDIRECT_ADDR),
        .iFETCH_STOP    (iFETCH_STOP),
        .iLOCK          (iLOCK),
        .oMEM_REQ       (oMEM_REQ),
        .oMEM_ADDR      (oMEM_ADDR),
        .iMEM_BUSY      (iMEM_BUSY),
        .iMEM_VALID     (iMEM_VALID),
        .iMEM_DATA      (iMEM_DATA),
        .iMEM_PAGEFAULT (iMEM_PAGEFAULT),
        .oINST_VALID    (oINST_VALID),
        .oINST          (oINST),
        .oPC            (oPC),
        .oPAGEFAULT     (oPAGEFAULT),
        .oFREE_REFRESH  (oFREE_REFRESH),
        .oERROR         (oERROR)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ 32'h0000_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic setIn(input logic stop, input logic lock, input logic busy,
                         input logic mv, input logic [31:0] md, input logic pf,
                         input logic rv, input logic [31:0] ra);
        iFETCH_STOP     = stop;
        iLOCK           = lock;
        iMEM_BUSY       = busy;
        iMEM_VALID      = mv;
        iMEM_DATA       = md;
        iMEM_PAGEFAULT  = pf;
        iREDIRECT_VALID = rv;
        iREDIRECT_ADDR  = ra;
        #2;
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    initial begin
        iRESET = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_req",    32'(oMEM_REQ), 0);
        chk("rst_ivalid", 32'(oINST_VALID), 0);
        chk("rst_inst",   oINST, 0);
        chk("rst_pc",     oPC, 0);
        chk("rst_pf",     32'(oPAGEFAULT), 0);
        chk("rst_fr",     32'(oFREE_REFRESH), 0);
        chk("rst_err",    32'(oERROR), 0);
        tick();
        tick();
        iRESET = 1'b0;

        // Four back-to-back requests, then the cap holds the fifth.
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c1_req", 32'(oMEM_REQ), 1); chk("c1_addr", oMEM_ADDR, 32'h0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c2_addr", oMEM_ADDR, 32'h4); chk("c2_req", 32'(oMEM_REQ), 1);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c3_addr", oMEM_ADDR, 32'h8);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c4_addr", oMEM_ADDR, 32'hC); chk("c4_req", 32'(oMEM_REQ), 1);
        tick();
        setIn(0, 0, 0, 1, memWord(32'h0), 0, 0, 0);
        chk("c5_cap_req", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c6_ivalid", 32'(oINST_VALID), 1);
        chk("c6_pc", oPC, 32'h0);
        chk("c6_inst", oINST, memWord(32'h0));
        chk("c6_req", 32'(oMEM_REQ), 1); chk("c6_addr", oMEM_ADDR, 32'h10);
        tick();
        setIn(0, 0, 0, 1, memWord(32'h4), 1, 0, 0);
        chk("c7_ivalid", 32'(oINST_VALID), 0);
        chk("c7_req", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 1, 1, memWord(32'h8), 0, 0, 0);
        chk("c8_ivalid", 32'(oINST_VALID), 1);
        chk("c8_pc", oPC, 32'h4);
        chk("c8_pf", 32'(oPAGEFAULT), 1);
        chk("c8_inst", oINST, memWord(32'h4));
        chk("c8_addr", oMEM_ADDR, 32'h14);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c9_pc", oPC, 32'h8); chk("c9_pf", 32'(oPAGEFAULT), 0);
        chk("c9_addr", oMEM_ADDR, 32'h14);
        tick();

        // Fetch stop for 10 cycles with 0xC, 0x10, 0x14 in flight.
        for (int i = 0; i < 10; i++) begin
            if (i == 2)      setIn(1, 0, 0, 1, memWord(32'hC), 0, 0, 0);
            else if (i == 4) setIn(1, 0, 0, 1, memWord(32'h10), 0, 0, 0);
            else if (i == 6) setIn(1, 0, 0, 1, memWord(32'h14), 0, 0, 0);
            else             setIn(1, 0, 0, 0, 0, 0, 0, 0);
            chk("stop_req", 32'(oMEM_REQ), 0);
            if (i == 3) begin
                chk("stop_v0", 32'(oINST_VALID), 1); chk("stop_pc0", oPC, 32'hC);
            end else if (i == 5) begin
                chk("stop_v1", 32'(oINST_VALID), 1); chk("stop_pc1", oPC, 32'h10);
            end else if (i == 7) begin
                chk("stop_v2", 32'(oINST_VALID), 1); chk("stop_pc2", oPC, 32'h14);
                chk("stop_inst2", oINST, memWord(32'h14));
            end else begin
                chk("stop_idle", 32'(oINST_VALID), 0);
            end
            tick();
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("resume_req", 32'(oMEM_REQ), 1); chk("resume_addr", oMEM_ADDR, 32'h18);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c21_addr", oMEM_ADDR, 32'h1C);
        tick();

        // Redirect to 0x1003 with 0x18 and 0x1C outstanding.
        setIn(0, 0, 0, 0, 0, 0, 1, 32'h1003);
        chk("rd1_req", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 1, memWord(32'h18), 0, 0, 0);
        chk("rd1_fr", 32'(oFREE_REFRESH), 1); chk("rd1_drain_req", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 1, memWord(32'h1C), 0, 0, 0);
        chk("rd1_fr_once", 32'(oFREE_REFRESH), 0);
        chk("rd1_drop0", 32'(oINST_VALID), 0);
        chk("rd1_drain_req2", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd1_drop1", 32'(oINST_VALID), 0);
        chk("rd1_new_req", 32'(oMEM_REQ), 1); chk("rd1_new_addr", oMEM_ADDR, 32'h1000);
        tick();
        setIn(0, 0, 1, 0, 0, 0, 0, 0);
        chk("c26_addr", oMEM_ADDR, 32'h1004);
        tick();
        setIn(0, 0, 0, 1, memWord(32'h1000), 0, 0, 0);
        chk("c27_addr", oMEM_ADDR, 32'h1004);
        tick();

        // Redirect to 0x200 then 0x300 while draining 0x1004.
        setIn(0, 0, 0, 0, 0, 0, 1, 32'h200);
        chk("rd1_fwd_v", 32'(oINST_VALID), 1); chk("rd1_fwd_pc", oPC, 32'h1000);
        chk("rd1_fwd_inst", oINST, memWord(32'h1000));
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd2_fr_a", 32'(oFREE_REFRESH), 1); chk("rd2_req_a", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 1, 32'h300);
        chk("rd2_fr_gap", 32'(oFREE_REFRESH), 0); chk("rd2_req_b", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 1, memWord(32'h1004), 0, 0, 0);
        chk("rd2_fr_b", 32'(oFREE_REFRESH), 1); chk("rd2_req_c", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd2_drop", 32'(oINST_VALID), 0); chk("rd2_fr_end", 32'(oFREE_REFRESH), 0);
        chk("rd2_req", 32'(oMEM_REQ), 1); chk("rd2_addr", oMEM_ADDR, 32'h300);
        tick();

        // Redirect coinciding with a response and a busy memory.
        setIn(0, 0, 1, 1, memWord(32'h300), 0, 1, 32'h400);
        chk("rd3_req", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 1, 0, 0, 0, 0, 0);
        chk("rd3_fr", 32'(oFREE_REFRESH), 1); chk("rd3_drop", 32'(oINST_VALID), 0);
        chk("rd3_req", 32'(oMEM_REQ), 1); chk("rd3_addr", oMEM_ADDR, 32'h400);
        tick();
        setIn(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rd3_withdraw", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd3_retry_addr", oMEM_ADDR, 32'h400); chk("rd3_retry_req", 32'(oMEM_REQ), 1);
        tick();
        setIn(0, 0, 1, 1, memWord(32'h400), 0, 0, 0);
        chk("rd3_next_addr", oMEM_ADDR, 32'h404);
        tick();
        setIn(0, 0, 1, 0, 0, 0, 0, 0);
        chk("rd3_fwd_v", 32'(oINST_VALID), 1); chk("rd3_fwd_pc", oPC, 32'h400);
        chk("rd3_err0", 32'(oERROR), 0);
        tick();

        // Spurious response with nothing outstanding.
        setIn(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        tick();
        setIn(0, 0, 1, 0, 0, 0, 0, 0);
        chk("sp_err", 32'(oERROR), 1); chk("sp_novalid", 32'(oINST_VALID), 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sp_sticky1", 32'(oERROR), 1); chk("sp_addr", oMEM_ADDR, 32'h404);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sp_sticky2", 32'(oERROR), 1); chk("sp_addr2", oMEM_ADDR, 32'h408);

        // Reset asserted mid-traffic.
        iRESET = 1'b1;
        #1;
        chk("mrst_err", 32'(oERROR), 0); chk("mrst_req", 32'(oMEM_REQ), 0);
        chk("mrst_addr", oMEM_ADDR, 32'h0);
        tick();
        iRESET = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mrst_req2", 32'(oMEM_REQ), 1); chk("mrst_addr2", oMEM_ADDR, 32'h0);
        chk("mrst_err2", 32'(oERROR), 0);
        tick();

        // Response while locked is forwarded and flags an error.
        setIn(0, 1, 0, 1, memWord(32'h0), 0, 0, 0);
        chk("lock_req", 32'(oMEM_REQ), 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lock_fwd", 32'(oINST_VALID), 1); chk("lock_pc", oPC, 32'h0);
        chk("lock_err", 32'(oERROR), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
